// File: rtl/pkt_pkg.sv
// Shared packet-bus definitions for the NanoCore 134b beat format.
// Beat layout: [133:132] tag, [131:128] valid nibble, [127:0] payload.
package pkt_pkg;

    localparam int DATA_W    = 134;
    localparam int TAG_LO    = DATA_W - 2;
    localparam int VNIB_LO   = DATA_W - 6;
    localparam int PAYLOAD_W = 128;

    localparam logic [1:0] TAG_MID    = 2'b00;
    localparam logic [1:0] TAG_HEAD   = 2'b01;
    localparam logic [1:0] TAG_TAIL   = 2'b10;
    localparam logic [1:0] TAG_SINGLE = 2'b11;

    localparam logic [DATA_W-1:0] TIMEOUT_BEAT = {TAG_TAIL, 4'h0, 128'h0};

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } arb_state_t;

    function automatic logic is_head(input logic [1:0] tag);
        return (tag == TAG_HEAD) || (tag == TAG_SINGLE);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first request after the last pointer wins.
// Returns both one-hot and encoded grant so other schedulers can reuse it.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int p;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        p   = 0;
        for (int k = 1; k <= N; k++) begin
            p = (int'(last) + k) % N;
            if (!any && req[p]) begin
                any    = 1'b1;
                gnt[p] = 1'b1;
                idx    = IDX_W'(p);
            end
        end
    end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter: grant is held from head to tail,
// orphan beats are discarded and stalled packets are closed by a timeout tail.
module pkt_rr_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int DATA_W      = pkt_pkg::DATA_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_PORTS-1:0]           i_req_valid,
    input  logic [NUM_PORTS*DATA_W-1:0]    i_req_data,
    output logic [NUM_PORTS-1:0]           o_req_ready,
    output logic                           o_data_valid,
    output logic [DATA_W-1:0]              o_data,
    input  logic                           i_alf,
    output logic [$clog2(NUM_PORTS)-1:0]   o_grant,
    output logic                           o_busy,
    output logic                           o_drop_pulse,
    output logic                           o_timeout_pulse
);

    import pkt_pkg::*;

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC - 1);

    arb_state_t state, state_nx;

    logic [IDX_W-1:0]     last;
    logic [IDX_W-1:0]     grant;
    logic [TMR_W-1:0]     timer;
    logic [NUM_PORTS-1:0] head_vec;
    logic [NUM_PORTS-1:0] orph_vec;
    logic [NUM_PORTS-1:0] pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic [IDX_W-1:0]     sel;
    logic [DATA_W-1:0]    sel_beat;
    logic [1:0]           sel_tag;
    logic [NUM_PORTS-1:0] ready;
    logic                 accept;
    logic                 drop;
    logic                 tmo;

    always_comb begin
        head_vec = '0;
        orph_vec = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            head_vec[p] = i_req_valid[p] &&
                          is_head(i_req_data[p*DATA_W + TAG_LO +: 2]);
            orph_vec[p] = i_req_valid[p] &&
                          !is_head(i_req_data[p*DATA_W + TAG_LO +: 2]);
        end
    end

    rr_picker #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req  (head_vec),
        .last (last),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign sel      = (state == ST_IDLE) ? pick_idx : grant;
    assign sel_beat = i_req_data[int'(sel)*DATA_W +: DATA_W];
    assign sel_tag  = sel_beat[TAG_LO +: 2];

    always_comb begin
        state_nx = state;
        ready    = '0;
        accept   = 1'b0;
        drop     = 1'b0;
        tmo      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // orphans are flushed even under back-pressure
                ready = orph_vec;
                drop  = |orph_vec;
                if (pick_any && !i_alf) begin
                    accept = 1'b1;
                    ready  = ready | pick_gnt;
                    if (sel_tag == TAG_HEAD)
                        state_nx = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (i_req_valid[grant] && !i_alf) begin
                    accept       = 1'b1;
                    ready[grant] = 1'b1;
                    if (sel_tag == TAG_TAIL)
                        state_nx = ST_IDLE;
                end else if (!i_req_valid[grant] && timer == TMR_MAX && !i_alf) begin
                    tmo      = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign o_req_ready = i_rst ? '0 : ready;
    assign o_grant     = grant;
    assign o_busy      = (state == ST_LOCK);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            last            <= IDX_W'(NUM_PORTS - 1);
            grant           <= '0;
            timer           <= '0;
            o_data_valid    <= 1'b0;
            o_data          <= '0;
            o_drop_pulse    <= 1'b0;
            o_timeout_pulse <= 1'b0;
        end else begin
            state           <= state_nx;
            o_data_valid    <= accept || tmo;
            o_drop_pulse    <= drop;
            o_timeout_pulse <= tmo;
            if (accept)
                o_data <= sel_beat;
            else if (tmo)
                o_data <= TIMEOUT_BEAT;
            if (state == ST_IDLE && accept) begin
                last  <= pick_idx;
                grant <= pick_idx;
            end
            // timer only counts cycles where the owner has nothing to offer
            if (state != ST_LOCK || accept || tmo)
                timer <= '0;
            else if (!i_req_valid[grant] && timer != TMR_MAX)
                timer <= timer + 1'b1;
        end
    end

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter: queue-fed sources, per-cycle output log,
// hand-computed expected sequences checked inside each scenario task.
module tb_pkt_rr_arbiter;

    localparam int NP = 2;
    localparam int DW = 134;
    localparam int TO = 8;

    localparam logic [1:0] T_MID    = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic clk = 1'b0;
    logic rst;
    logic [NP-1:0]    req_valid;
    logic [NP*DW-1:0] req_data;
    logic [NP-1:0]    req_ready;
    logic             data_valid;
    logic [DW-1:0]    data;
    logic             alf;
    logic [0:0]       grant;
    logic             busy;
    logic             drop_pulse;
    logic             timeout_pulse;

    logic [DW-1:0] to_beat;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic          log_v[$];
    logic [DW-1:0] log_d[$];
    logic [NP-1:0] log_r[$];
    logic          log_drop[$];
    logic          log_to[$];
    logic          log_busy[$];
    logic [0:0]    log_g[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pkt_rr_arbiter #(
        .NUM_PORTS   (NP),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_req_valid     (req_valid),
        .i_req_data      (req_data),
        .o_req_ready     (req_ready),
        .o_data_valid    (data_valid),
        .o_data          (data),
        .i_alf           (alf),
        .o_grant         (grant),
        .o_busy          (busy),
        .o_drop_pulse    (drop_pulse),
        .o_timeout_pulse (timeout_pulse)
    );

    function automatic logic [DW-1:0] bt(input logic [1:0] tag, input logic [31:0] v);
        return {tag, 4'hF, 96'h0, v};
    endfunction

    task automatic clear_logs();
        log_v.delete();
        log_d.delete();
        log_r.delete();
        log_drop.delete();
        log_to.delete();
        log_busy.delete();
        log_g.delete();
    endtask

    // one clock: present queue heads, capture ready, pop accepted, log outputs
    task automatic step();
        logic [NP-1:0] r;
        req_valid[0]       = (q0.size() != 0);
        req_data[0 +: DW]  = (q0.size() != 0) ? q0[0] : '0;
        req_valid[1]       = (q1.size() != 0);
        req_data[DW +: DW] = (q1.size() != 0) ? q1[0] : '0;
        #1;
        r = req_ready;
        @(posedge clk);
        #1;
        if (r[0] && q0.size() != 0) void'(q0.pop_front());
        if (r[1] && q1.size() != 0) void'(q1.pop_front());
        log_r.push_back(r);
        log_v.push_back(data_valid);
        log_d.push_back(data);
        log_drop.push_back(drop_pulse);
        log_to.push_back(timeout_pulse);
        log_busy.push_back(busy);
        log_g.push_back(grant);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alf = 1'b0;
        q0.delete();
        q1.delete();
        step();
        step();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        alf = 1'b0;
        clear_logs();
        q0.push_back(bt(T_HEAD, 32'h1));
        q1.push_back(bt(T_MID, 32'h2));
        step();
        n_tests++;
        if (log_r[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 00", log_r[0]);
        end
        n_tests++;
        if (data_valid !== 1'b0 || data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got v=%b d=%h want v=0 d=0", data_valid, data);
        end
        n_tests++;
        if (busy !== 1'b0 || grant !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b grant=%b want 0 0", busy, grant);
        end
        n_tests++;
        if (drop_pulse !== 1'b0 || timeout_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got drop=%b to=%b want 0 0", drop_pulse, timeout_pulse);
        end
        q0.delete();
        q1.delete();
        rst = 1'b0;
    endtask

    task automatic test_single_port();
        logic [DW-1:0] exp_d[3];
        do_reset();
        exp_d[0] = bt(T_HEAD, 32'hA0);
        exp_d[1] = bt(T_MID, 32'hA1);
        exp_d[2] = bt(T_TAIL, 32'hA2);
        for (int i = 0; i < 3; i++) q0.push_back(exp_d[i]);
        repeat (5) step();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (log_v[i] !== 1'b1 || log_d[i] !== exp_d[i] || log_g[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL single_beat%0d: got v=%b g=%b d=%h want d=%h g=0",
                         i, log_v[i], log_g[i], log_d[i], exp_d[i]);
            end
        end
        n_tests++;
        if (log_v[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got v=%b want 0", log_v[3]);
        end
        n_tests++;
        if (log_busy[0] !== 1'b1 || log_busy[1] !== 1'b1 || log_busy[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy: got %b%b%b want 110",
                     log_busy[0], log_busy[1], log_busy[2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_d[4];
        logic [0:0]    exp_g[4];
        do_reset();
        exp_d[0] = bt(T_HEAD, 32'h10);
        exp_d[1] = bt(T_TAIL, 32'h11);
        exp_d[2] = bt(T_HEAD, 32'h20);
        exp_d[3] = bt(T_TAIL, 32'h21);
        exp_g[0] = 1'b0;
        exp_g[1] = 1'b0;
        exp_g[2] = 1'b1;
        exp_g[3] = 1'b1;
        q0.push_back(exp_d[0]);
        q0.push_back(exp_d[1]);
        q1.push_back(exp_d[2]);
        q1.push_back(exp_d[3]);
        repeat (5) step();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (log_v[i] !== 1'b1 || log_d[i] !== exp_d[i] || log_g[i] !== exp_g[i]) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got v=%b g=%b d=%h want d=%h g=%b",
                         i, log_v[i], log_g[i], log_d[i], exp_d[i], exp_g[i]);
            end
        end
        n_tests++;
        if (log_v[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got v=%b want 0", log_v[4]);
        end
    endtask

    task automatic test_fairness();
        logic [DW-1:0] exp_d[5];
        logic [0:0]    exp_g[5];
        do_reset();
        for (int i = 0; i < 4; i++) q0.push_back(bt(T_SINGLE, 32'h30 + i));
        q1.push_back(bt(T_SINGLE, 32'h40));
        exp_d[0] = bt(T_SINGLE, 32'h30);
        exp_d[1] = bt(T_SINGLE, 32'h40);
        exp_d[2] = bt(T_SINGLE, 32'h31);
        exp_d[3] = bt(T_SINGLE, 32'h32);
        exp_d[4] = bt(T_SINGLE, 32'h33);
        exp_g[0] = 1'b0;
        exp_g[1] = 1'b1;
        exp_g[2] = 1'b0;
        exp_g[3] = 1'b0;
        exp_g[4] = 1'b0;
        repeat (6) step();
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (log_v[i] !== 1'b1 || log_d[i] !== exp_d[i] || log_g[i] !== exp_g[i]) begin
                n_fail++;
                $display("FAIL rr_order%0d: got v=%b g=%b d=%h want d=%h g=%b",
                         i, log_v[i], log_g[i], log_d[i], exp_d[i], exp_g[i]);
            end
        end
        n_tests++;
        if (log_busy[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_busy: got %b want 0", log_busy[4]);
        end
    endtask

    task automatic test_alf();
        logic [DW-1:0] exp_d[4];
        logic [NP-1:0] r_or;
        int            v_cnt;
        int            seen;
        int            to_cnt;
        do_reset();
        exp_d[0] = bt(T_HEAD, 32'h50);
        exp_d[1] = bt(T_MID, 32'h51);
        exp_d[2] = bt(T_MID, 32'h52);
        exp_d[3] = bt(T_TAIL, 32'h53);
        for (int i = 0; i < 4; i++) q0.push_back(exp_d[i]);
        step();
        alf = 1'b1;
        repeat (10) step();
        alf = 1'b0;
        repeat (4) step();
        r_or  = '0;
        v_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            r_or  = r_or | log_r[i];
            v_cnt = v_cnt + int'(log_v[i]);
        end
        n_tests++;
        if (r_or !== 2'b00) begin
            n_fail++;
            $display("FAIL alf_ready: got %b want 00", r_or);
        end
        n_tests++;
        if (v_cnt > 1) begin
            n_fail++;
            $display("FAIL alf_skid: got %0d beats want <=1", v_cnt);
        end
        n_tests++;
        if (log_busy[10] !== 1'b1) begin
            n_fail++;
            $display("FAIL alf_busy: got %b want 1", log_busy[10]);
        end
        seen   = 0;
        to_cnt = 0;
        for (int i = 0; i < log_v.size(); i++) begin
            to_cnt = to_cnt + int'(log_to[i]);
            if (log_v[i] === 1'b1) begin
                n_tests++;
                if (seen >= 4 || log_d[i] !== exp_d[seen % 4]) begin
                    n_fail++;
                    $display("FAIL alf_beat%0d: got %h want %h", seen, log_d[i], exp_d[seen % 4]);
                end
                seen++;
            end
        end
        n_tests++;
        if (seen !== 4 || to_cnt !== 0) begin
            n_fail++;
            $display("FAIL alf_count: got beats=%0d timeouts=%0d want 4 0", seen, to_cnt);
        end
    endtask

    task automatic test_orphan();
        do_reset();
        q1.push_back(bt(T_MID, 32'h60));
        step();
        step();
        n_tests++;
        if (log_r[0] !== 2'b10 || log_drop[0] !== 1'b1 || log_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL orphan_mid: got r=%b drop=%b v=%b want 10 1 0",
                     log_r[0], log_drop[0], log_v[0]);
        end
        n_tests++;
        if (log_drop[1] !== 1'b0 || q1.size() !== 0) begin
            n_fail++;
            $display("FAIL orphan_pulse: got drop=%b left=%0d want 0 0", log_drop[1], q1.size());
        end
        alf = 1'b1;
        q1.push_back(bt(T_TAIL, 32'h61));
        step();
        alf = 1'b0;
        n_tests++;
        if (log_r[2] !== 2'b10 || log_drop[2] !== 1'b1 || log_v[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL orphan_alf: got r=%b drop=%b v=%b want 10 1 0",
                     log_r[2], log_drop[2], log_v[2]);
        end
    endtask

    task automatic test_timeout();
        logic [NP-1:0] r_or;
        logic          v_or;
        logic          to_or;
        do_reset();
        q0.push_back(bt(T_HEAD, 32'h70));
        q1.push_back(bt(T_HEAD, 32'h80));
        repeat (11) step();
        n_tests++;
        if (log_v[0] !== 1'b1 || log_d[0] !== bt(T_HEAD, 32'h70) || log_g[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL to_head: got v=%b g=%b d=%h", log_v[0], log_g[0], log_d[0]);
        end
        r_or  = '0;
        v_or  = 1'b0;
        to_or = 1'b0;
        for (int i = 0; i <= 8; i++) r_or = r_or | log_r[i];
        for (int i = 1; i <= 7; i++) begin
            v_or  = v_or | log_v[i];
            to_or = to_or | log_to[i];
        end
        n_tests++;
        if (v_or !== 1'b0 || to_or !== 1'b0) begin
            n_fail++;
            $display("FAIL to_early: got v=%b pulse=%b want 0 0", v_or, to_or);
        end
        n_tests++;
        if (r_or[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL to_p1_held: got ready1=%b want 0", r_or[1]);
        end
        n_tests++;
        if (log_v[8] !== 1'b1 || log_d[8] !== to_beat || log_to[8] !== 1'b1) begin
            n_fail++;
            $display("FAIL to_tail: got v=%b pulse=%b d=%h want 1 1 %h",
                     log_v[8], log_to[8], log_d[8], to_beat);
        end
        n_tests++;
        if (log_v[9] !== 1'b1 || log_d[9] !== bt(T_HEAD, 32'h80) ||
            log_g[9] !== 1'b1 || log_busy[9] !== 1'b1) begin
            n_fail++;
            $display("FAIL to_next: got v=%b g=%b busy=%b d=%h",
                     log_v[9], log_g[9], log_busy[9], log_d[9]);
        end
        rst = 1'b1;
        q1.push_back(bt(T_MID, 32'h81));
        step();
        n_tests++;
        if (data_valid !== 1'b0 || data !== '0 || busy !== 1'b0 || grant !== 1'b0 ||
            drop_pulse !== 1'b0 || timeout_pulse !== 1'b0 || log_r[11] !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b busy=%b g=%b drop=%b to=%b r=%b d=%h",
                     data_valid, busy, grant, drop_pulse, timeout_pulse, log_r[11], data);
        end
        rst = 1'b0;
        q1.delete();
    endtask

    initial begin
        to_beat   = {2'b10, 4'h0, 128'h0};
        rst       = 1'b1;
        alf       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_port();
        test_back_to_back();
        test_fairness();
        test_alf();
        test_orphan();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
